mem_port_arbiter: RTL

- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store unit, LSU).
- Serialises requests into one outstanding memory transaction and returns the response to the owner.
- Generates the stall requests that the pipeline stall/flush logic ORs into its PC, IF/ID and ID/EX stall controls.
- Sits between the pipeline stages and the memory model/bus.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LSU memory port arbiter: FSM state, transaction owner and the
// latched memory request.
package mem_arb_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnLsu} owner_e;

  typedef struct packed {
    logic                 we;
    logic [AddrW-1:0]     addr;
    logic [DataW-1:0]     wdata;
    logic [DataW/8-1:0]   strb;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline and memory-side handshake bundle of mem_port_arbiter. The slave modport is the
// arbiter's view; the master modport drives the pipeline/memory inputs.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) ();

  logic                i_if_req;
  logic [ADDR_W-1:0]   i_if_addr;
  logic                i_flush_if;
  logic                o_if_ack;
  logic [DATA_W-1:0]   o_if_rdata;

  logic                i_lsu_req;
  logic                i_lsu_we;
  logic [ADDR_W-1:0]   i_lsu_addr;
  logic [DATA_W-1:0]   i_lsu_wdata;
  logic [DATA_W/8-1:0] i_lsu_strb;
  logic                o_lsu_ack;
  logic [DATA_W-1:0]   o_lsu_rdata;

  logic                o_mem_req;
  logic                o_mem_we;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [DATA_W-1:0]   o_mem_wdata;
  logic [DATA_W/8-1:0] o_mem_strb;
  logic                i_mem_ready;
  logic                i_mem_rvalid;
  logic [DATA_W-1:0]   i_mem_rdata;

  logic                o_stall_if;
  logic                o_stall_mem;
  logic                o_err;

  modport slave (
    input  i_if_req, i_if_addr, i_flush_if,
    output o_if_ack, o_if_rdata,
    input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_strb,
    output o_lsu_ack, o_lsu_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_strb,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_stall_if, o_stall_mem, o_err
  );

  modport master (
    output i_if_req, i_if_addr, i_flush_if,
    input  o_if_ack, o_if_rdata,
    output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_strb,
    input  o_lsu_ack, o_lsu_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_strb,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_stall_if, o_stall_mem, o_err
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selector. Fixed LSU priority by default; MEM_ARB_RR_EN switches ties
// to round-robin against the last-grant bit (1 = LSU granted last).
module mem_arb_pick (
  input  logic if_req,
  input  logic lsu_req,
  input  logic last_lsu,
  output logic gnt_if,
  output logic gnt_lsu
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    gnt_lsu = lsu_req && !(if_req && last_lsu);
    gnt_if  = if_req && !gnt_lsu;
  end
`else
  logic unused_last;
  assign unused_last = last_lsu;

  always_comb begin
    gnt_lsu = lsu_req;
    gnt_if  = if_req && !lsu_req;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU, one transaction at a
// time, with stall generation and a sticky WAIT timeout. Build option: MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = AddrW,
  parameter int unsigned DATA_W  = DataW,
  parameter int unsigned TIMEOUT = 64
) (
  input logic             i_clk,
  input logic             i_rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  mem_req_t            req_q, req_d;
  logic                drop_q, drop_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                if_ack_q, if_ack_d, lsu_ack_q, lsu_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic                err_q, err_d;
  logic                last_lsu_q, last_lsu_d;
  logic                ack_busy, gnt_if, gnt_lsu, flush_own;

  // The acked requester still holds its old req during the ack cycle, so no grant then.
  assign ack_busy  = if_ack_q || lsu_ack_q;
  assign flush_own = bus.i_flush_if && (owner_q == OwnIf);

  mem_arb_pick u_pick (
    .if_req   (bus.i_if_req && !bus.i_flush_if && !ack_busy),
    .lsu_req  (bus.i_lsu_req && !ack_busy),
    .last_lsu (last_lsu_q),
    .gnt_if   (gnt_if),
    .gnt_lsu  (gnt_lsu)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_d       = req_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    if_ack_d    = 1'b0;
    lsu_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    err_d       = err_q;
    last_lsu_d  = last_lsu_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_lsu) begin
          req_d      = '{we: bus.i_lsu_we, addr: bus.i_lsu_addr, wdata: bus.i_lsu_wdata,
                         strb: bus.i_lsu_strb};
          owner_d    = OwnLsu;
          last_lsu_d = 1'b1;
          state_d    = StReq;
        end else if (gnt_if) begin
          req_d      = '{we: 1'b0, addr: bus.i_if_addr, wdata: '0, strb: '0};
          owner_d    = OwnIf;
          last_lsu_d = 1'b0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (flush_own) drop_d = 1'b1;
        if (bus.i_mem_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (flush_own) drop_d = 1'b1;
        if (bus.i_mem_rvalid) begin
          state_d = StIdle;
          owner_d = OwnNone;
          drop_d  = 1'b0;
          if (owner_q == OwnLsu) begin
            lsu_ack_d   = 1'b1;
            lsu_rdata_d = bus.i_mem_rdata;
          end else if (!drop_q && !flush_own) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.i_mem_rdata;
          end
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
          owner_d = OwnNone;
          drop_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      req_q       <= '0;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      if_ack_q    <= 1'b0;
      lsu_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
      err_q       <= 1'b0;
      last_lsu_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_q       <= req_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      if_ack_q    <= if_ack_d;
      lsu_ack_q   <= lsu_ack_d;
      if_rdata_q  <= if_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      err_q       <= err_d;
      last_lsu_q  <= last_lsu_d;
    end
  end

  assign bus.o_mem_req   = (state_q == StReq);
  assign bus.o_mem_we    = req_q.we;
  assign bus.o_mem_addr  = req_q.addr;
  assign bus.o_mem_wdata = req_q.wdata;
  assign bus.o_mem_strb  = req_q.strb;
  // A branch in the ack cycle must never see a fetch ack.
  assign bus.o_if_ack    = if_ack_q && !bus.i_flush_if;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_lsu_ack   = lsu_ack_q;
  assign bus.o_lsu_rdata = lsu_rdata_q;
  assign bus.o_stall_if  = !i_rst && bus.i_if_req && !bus.o_if_ack;
  assign bus.o_stall_mem = !i_rst && bus.i_lsu_req && !lsu_ack_q;
  assign bus.o_err       = err_q;

endmodule
